// File: rtl/rom_arb.sv
// Two-master arbiter (loader m0, fetch m1) in front of a single-port rom, burst-limited with fair hand-over.
// Optional write protection of the low region is enabled by defining ROM_ARB_WP_EN.
module rom_arb #(
  parameter int unsigned MAX_BURST = 4,
  parameter logic [31:0] WP_LIMIT  = 32'h400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        hold_flag_o,
  output logic        rom_we_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_data_o,
  input  logic [31:0] rom_data_i
);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

  localparam int CW = $clog2(MAX_BURST + 1);

  owner_t        owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          burst_full;
  logic          sel_m0, sel_m1;
  logic          wp_hit;
  logic          m0_rvalid_q, m1_rvalid_q, m0_err_q;
  logic [31:0]   m0_rdata_q, m1_rdata_q;

`ifdef ROM_ARB_WP_EN
  assign wp_hit = m0_we_i && (m0_addr_i < WP_LIMIT);
`else
  logic unused_wp;
  assign wp_hit    = 1'b0;
  assign unused_wp = ^WP_LIMIT;
`endif

  assign burst_full = (cnt >= CW'(MAX_BURST));
  assign cnt_inc    = burst_full ? cnt : cnt + CW'(1);

  // State register: owner and saturating beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= OWN_NONE;
      cnt   <= '0;
    end else begin
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: the owner keeps the slot until its burst is spent and the other side waits.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    sel_m0    = 1'b0;
    sel_m1    = 1'b0;
    owner_nxt = OWN_NONE;
    cnt_nxt   = '0;
    case (owner)
      OWN_M0: begin
        if (m0_req_i && (!burst_full || !m1_req_i)) sel_m0 = 1'b1;
        else if (m1_req_i)                          sel_m1 = 1'b1;
      end
      OWN_M1: begin
        if (m1_req_i && (!burst_full || !m0_req_i)) sel_m1 = 1'b1;
        else if (m0_req_i)                          sel_m0 = 1'b1;
      end
      default: begin
        if (m0_req_i)      sel_m0 = 1'b1;
        else if (m1_req_i) sel_m1 = 1'b1;
      end
    endcase
    if (rst) begin
      sel_m0 = 1'b0;
      sel_m1 = 1'b0;
    end
    if (sel_m0) begin
      owner_nxt = OWN_M0;
      cnt_nxt   = (owner == OWN_M0) ? cnt_inc : CW'(1);
    end else if (sel_m1) begin
      owner_nxt = OWN_M1;
      cnt_nxt   = (owner == OWN_M1) ? cnt_inc : CW'(1);
    end
  end

  // Outputs: grants, rom access mux and stall flag.
  always_comb begin
    m0_gnt_o   = sel_m0;
    m1_gnt_o   = sel_m1;
    rom_we_o   = sel_m0 && m0_we_i && !wp_hit;
    rom_addr_o = '0;
    rom_data_o = '0;
    if (sel_m0) begin
      rom_addr_o = m0_addr_i;
      rom_data_o = m0_data_i;
    end else if (sel_m1) begin
      rom_addr_o = m1_addr_i;
    end
    hold_flag_o = m1_req_i && !sel_m1;
  end

  // Registered read return path and protection error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= sel_m0 && !m0_we_i;
      m1_rvalid_q <= sel_m1;
      m0_err_q    <= sel_m0 && wp_hit;
      if (sel_m0 && !m0_we_i) m0_rdata_q <= rom_data_i;
      if (sel_m1)             m1_rdata_q <= rom_data_i;
    end
  end

  // NOTE: pulses are masked while rst is high so a read granted just before reset never shows rvalid.
  assign m0_rvalid_o = m0_rvalid_q && !rst;
  assign m1_rvalid_o = m1_rvalid_q && !rst;
  assign m0_err_o    = m0_err_q && !rst;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule
